// File: rtl/req_panel_pkg.sv
// Shared constants and types for the floor request panel and the elevator controller.
package req_panel_pkg;

    localparam int N_FLOORS   = 3;
    localparam int DB_SAMPLES = 2;

    // Floor bit positions inside every per-floor vector
    localparam int FLOOR_1 = 0;
    localparam int FLOOR_2 = 1;
    localparam int FLOOR_3 = 2;

    localparam int CNT_W = 2;

    typedef logic [CNT_W-1:0] pending_cnt_t;

    typedef struct packed {
        logic         valid;
        pending_cnt_t cnt;
    } panel_status_t;

endpackage

// File: rtl/req_panel_if.sv
// Signal bundle between the elevator controller (master) and the request panel (slave).
interface req_panel_if #(
    parameter int N_FLOORS = req_panel_pkg::N_FLOORS
);

    logic [N_FLOORS-1:0]         btn;
    logic [N_FLOORS-1:0]         at_floor;
    logic                        door_open;
    logic [N_FLOORS-1:0]         served;
    logic [N_FLOORS-1:0]         req;
    logic                        req_valid;
    req_panel_pkg::pending_cnt_t pending_cnt;

    modport master (
        output btn,
        output at_floor,
        output door_open,
        output served,
        input  req,
        input  req_valid,
        input  pending_cnt
    );

    modport slave (
        input  btn,
        input  at_floor,
        input  door_open,
        input  served,
        output req,
        output req_valid,
        output pending_cnt
    );

endinterface

// File: rtl/req_panel_btn_debounce.sv
// One push-button front end: two-flop synchronizer, run-length debounce and a
// one-cycle press strobe on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DB_SAMPLES = req_panel_pkg::DB_SAMPLES
) (
    input  logic clk10hz,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int            CW       = $clog2(DB_SAMPLES + 1);
    localparam logic [CW-1:0] RUN_DONE = CW'(DB_SAMPLES);
    localparam logic [CW-1:0] RUN_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    logic          level_next_s;
    logic [CW-1:0] cnt_next_s;
    logic [CW-1:0] run_s;

    // Run length counts the sample entering the second stage, so the settled
    // level lands one edge after the synchronizer output; the run only extends
    // while the sample already held in the second stage also disagrees.
    always_comb begin
        run_s        = RUN_ONE;
        cnt_next_s   = '0;
        level_next_s = level_r;
        if (sync1_r != level_r) begin
            if (sync2_r != level_r) begin
                run_s = cnt_r + RUN_ONE;
            end else begin
                run_s = RUN_ONE;
            end
            if (run_s >= RUN_DONE) begin
                cnt_next_s   = '0;
                level_next_s = sync1_r;
            end else begin
                cnt_next_s   = run_s;
                level_next_s = level_r;
            end
        end else begin
            run_s        = RUN_ONE;
            cnt_next_s   = '0;
            level_next_s = level_r;
        end
    end

    // Synchronizer, debounce state and press strobe registers
    always_ff @(posedge clk10hz) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= '0;
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_next_s;
            level_r <= level_next_s;
            press_r <= level_next_s & ~level_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/req_panel.sv
// Floor request panel: latches debounced button presses as pending requests
// until the controller reports the floor served.
module req_panel #(
    parameter int N_FLOORS   = req_panel_pkg::N_FLOORS,
    parameter int DB_SAMPLES = req_panel_pkg::DB_SAMPLES
) (
    input  logic       clk10hz,
    input  logic       rst,
    req_panel_if.slave bus
);

    logic [N_FLOORS-1:0]          press_s;
    logic [N_FLOORS-1:0]          req_next_s;
    logic [N_FLOORS-1:0]          req_r;
    req_panel_pkg::panel_status_t status_next_s;
    req_panel_pkg::panel_status_t status_r;

    for (genvar i = 0; i < N_FLOORS; i++) begin : g_floor
        btn_debounce #(
            .DB_SAMPLES(DB_SAMPLES)
        ) u_btn_debounce (
            .clk10hz(clk10hz),
            .rst    (rst),
            .btn    (bus.btn[i]),
            .press  (press_s[i])
        );
    end

    // Per-floor latch: a clear always beats a press; a press at the open door of
    // the current floor is already being served and is absorbed.
    always_comb begin
        req_next_s = req_r;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (bus.served[i]) begin
                req_next_s[i] = 1'b0;
            end else if (press_s[i] && !(bus.door_open && bus.at_floor[i])) begin
                req_next_s[i] = 1'b1;
            end else begin
                req_next_s[i] = req_r[i];
            end
        end
    end

    // Status is derived from the next request vector so it lines up with req
    always_comb begin
        status_next_s = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            status_next_s.cnt = status_next_s.cnt + {1'b0, req_next_s[i]};
        end
        status_next_s.valid = |req_next_s;
    end

    // Request and status registers
    always_ff @(posedge clk10hz) begin
        if (rst) begin
            req_r    <= '0;
            status_r <= '0;
        end else begin
            req_r    <= req_next_s;
            status_r <= status_next_s;
        end
    end

    assign bus.req         = req_r;
    assign bus.req_valid   = status_r.valid;
    assign bus.pending_cnt = status_r.cnt;

endmodule

// File: tb/tb_req_panel.sv
// Directed scenarios plus random button/served traffic for req_panel, every edge
// compared against a sample-window reference model of the panel.
module tb_req_panel;
    import req_panel_pkg::*;

    localparam int NF = N_FLOORS;
    localparam int DB = DB_SAMPLES;

    logic clk10hz = 1'b0;
    logic rst     = 1'b1;

    req_panel_if bus ();

    req_panel dut (
        .clk10hz(clk10hz),
        .rst    (rst),
        .bus    (bus)
    );

    always #50 clk10hz = ~clk10hz;

    int total = 0;
    int bad   = 0;

    // Reference model: raw samples per edge, debounced level, press event, requests
    logic [NF-1:0] m_hist [DB];
    logic [NF-1:0] m_level;
    logic [NF-1:0] m_press;
    logic [NF-1:0] m_req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Level flips once the last DB raw samples (taken before this edge) all disagree with it
    task automatic model_edge(input logic r, input logic [NF-1:0] b, input logic [NF-1:0] srv,
                              input logic [NF-1:0] at, input logic door);
        logic flip;
        if (r) begin
            m_req   = '0;
            m_level = '0;
            m_press = '0;
            for (int j = 0; j < DB; j++) m_hist[j] = '0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (srv[i]) m_req[i] = 1'b0;
                else if (m_press[i] && !(door && at[i])) m_req[i] = 1'b1;
            end
            for (int i = 0; i < NF; i++) begin
                flip = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    if (m_hist[j][i] == m_level[i]) flip = 1'b0;
                end
                m_press[i] = flip && !m_level[i];
                if (flip) m_level[i] = !m_level[i];
            end
            for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = b;
        end
    endtask

    task automatic tick();
        @(posedge clk10hz);
        model_edge(rst, bus.btn, bus.served, bus.at_floor, bus.door_open);
        #1;
        check("req", bus.req, m_req);
        check("req_valid", bus.req_valid, |m_req);
        check("pending_cnt", bus.pending_cnt, $countones(m_req));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        bus.btn       = '0;
        bus.served    = '0;
        bus.at_floor  = 3'b001;
        bus.door_open = 1'b0;
        rst           = 1'b1;
        ticks(2);
        check("reset_req", bus.req, 3'b000);
        check("reset_valid", bus.req_valid, 1'b0);
        check("reset_cnt", bus.pending_cnt, 2'd0);

        // Top floor press: latency to E4, then served clears it
        rst     = 1'b0;
        bus.btn = 3'b100;
        ticks(3);
        check("lat_e3_req", bus.req, 3'b000);
        tick();
        check("lat_e4_req", bus.req, 3'b100);
        check("lat_e4_valid", bus.req_valid, 1'b1);
        check("lat_e4_cnt", bus.pending_cnt, 2'd1);
        ticks(2);
        bus.btn    = 3'b000;
        bus.served = 3'b100;
        tick();
        bus.served = 3'b000;
        check("served_req", bus.req, 3'b000);
        check("served_cnt", bus.pending_cnt, 2'd0);
        ticks(3);

        // Single-cycle glitch
        bus.btn = 3'b001;
        tick();
        bus.btn = 3'b000;
        ticks(5);
        check("glitch_req", bus.req, 3'b000);

        // Press absorbed at the open door of the current floor, accepted once closed
        bus.at_floor  = 3'b001;
        bus.door_open = 1'b1;
        bus.btn       = 3'b001;
        ticks(5);
        check("absorb_req", bus.req, 3'b000);
        bus.btn = 3'b000;
        ticks(3);
        bus.door_open = 1'b0;
        bus.btn       = 3'b001;
        ticks(4);
        check("door_closed_req", bus.req, 3'b001);
        bus.btn    = 3'b000;
        bus.served = 3'b001;
        tick();
        bus.served = 3'b000;
        ticks(2);

        // Served and a new press event on the same edge: clear wins
        bus.btn = 3'b010;
        ticks(4);
        check("pend1_req", bus.req, 3'b010);
        bus.btn = 3'b000;
        ticks(3);
        bus.btn = 3'b010;
        ticks(3);
        bus.served = 3'b010;
        tick();
        bus.served = 3'b000;
        check("clear_wins_req", bus.req, 3'b000);
        ticks(2);
        check("held_no_repress", bus.req, 3'b000);
        bus.btn = 3'b000;
        ticks(3);

        // Several floors at once
        bus.btn = 3'b101;
        ticks(4);
        check("multi_req", bus.req, 3'b101);
        check("multi_cnt", bus.pending_cnt, 2'd2);
        bus.btn = 3'b111;
        ticks(4);
        check("all_cnt", bus.pending_cnt, 2'd3);
        bus.btn    = 3'b000;
        bus.served = 3'b111;
        tick();
        bus.served = 3'b000;
        check("all_served_req", bus.req, 3'b000);
        check("all_served_valid", bus.req_valid, 1'b0);
        ticks(3);

        // Reset with requests pending and a button held through it
        bus.btn = 3'b110;
        ticks(4);
        check("pre_rst_req", bus.req, 3'b110);
        bus.btn = 3'b100;
        ticks(3);
        rst = 1'b1;
        tick();
        check("rst_edge_req", bus.req, 3'b000);
        check("rst_edge_cnt", bus.pending_cnt, 2'd0);
        rst = 1'b0;
        ticks(3);
        check("post_rst_e3", bus.req, 3'b000);
        tick();
        check("post_rst_e4", bus.req, 3'b100);
        bus.btn    = 3'b000;
        bus.served = 3'b011;
        tick();
        check("served_nonpending", bus.req, 3'b100);
        bus.served = 3'b100;
        tick();
        bus.served = 3'b000;
        ticks(3);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 3) == 0) bus.btn[i] = ~bus.btn[i];
                bus.served[i] = ($urandom_range(0, 7) == 0);
            end
            bus.door_open = 1'($urandom_range(0, 1));
            bus.at_floor  = '0;
            bus.at_floor[$urandom_range(0, NF - 1)] = 1'b1;
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
